bit_serializer: RTL and testbench

BIT_SERIALIZER -- requirements
Module: bit_serializer

---
 rtl/bit_serializer_pkg.sv | 12 +
 rtl/bit_serializer.sv | 83 ++++++++
 tb/tb_bit_serializer.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/bit_serializer_pkg.sv
// Shared definitions for the bit serializer and the sequence-detector bench.
// Holds the FSM state encoding and the default parallel word width.
package bit_serializer_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } state_e;

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial converter with valid/ready intake and registered serial outputs.
// Words stream back-to-back when a new word is offered during the last bit.
module bit_serializer
   import bit_serializer_pkg::*;
#(
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   output logic             din_ready,
   output logic             w,
   output logic             w_valid,
   output logic             sof,
   output logic             busy
);

   localparam int            CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_e           state_q;
   logic [CW-1:0]    cnt_q;
   logic [WIDTH-1:0] sreg_q, sreg_d;
   logic             w_q, w_valid_q, sof_q, busy_q;
   logic             last, xfer;

   function automatic logic head(input logic [WIDTH-1:0] v);
      return MSB_FIRST ? v[WIDTH-1] : v[0];
   endfunction

   assign last      = (cnt_q == LAST);
   assign din_ready = (state_q == IDLE) || last;
   assign xfer      = din_valid && din_ready;

   // The register always holds the remaining bits with the visible one at the head.
   always_comb begin
      sreg_d = MSB_FIRST ? {sreg_q[WIDTH-2:0], 1'b0} : {1'b0, sreg_q[WIDTH-1:1]};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         sreg_q    <= '0;
         w_q       <= 1'b0;
         w_valid_q <= 1'b0;
         sof_q     <= 1'b0;
         busy_q    <= 1'b0;
      end else if (xfer) begin
         state_q   <= SHIFT;
         cnt_q     <= '0;
         sreg_q    <= din;
         w_q       <= head(din);
         w_valid_q <= 1'b1;
         sof_q     <= 1'b1;
         busy_q    <= 1'b1;
      end else if (state_q == SHIFT) begin
         if (!last) begin
            cnt_q  <= cnt_q + 1'b1;
            sreg_q <= sreg_d;
            w_q    <= head(sreg_d);
            sof_q  <= 1'b0;
         end else begin
            // Drop to a clean all-zero idle stream for the downstream detector.
            state_q   <= IDLE;
            cnt_q     <= '0;
            sreg_q    <= '0;
            w_q       <= 1'b0;
            w_valid_q <= 1'b0;
            sof_q     <= 1'b0;
            busy_q    <= 1'b0;
         end
      end
   end

   assign w       = w_q;
   assign w_valid = w_valid_q;
   assign sof     = sof_q;
   assign busy    = busy_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: vector table, corner sequences and a queue-based random model.
// Two instances cover MSB-first and LSB-first ordering.
module tb_bit_serializer;
   import bit_serializer_pkg::*;

   localparam int W = DEFAULT_WIDTH;

   logic         clk = 1'b0;
   logic         reset;
   logic [W-1:0] din_m, din_l;
   logic         dv_m, dv_l;
   logic         rdy_m, w_m, wv_m, sof_m, busy_m;
   logic         rdy_l, w_l, wv_l, sof_l, busy_l;

   always #5 clk = ~clk;

   bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
      .clk(clk), .reset(reset), .din(din_m), .din_valid(dv_m), .din_ready(rdy_m),
      .w(w_m), .w_valid(wv_m), .sof(sof_m), .busy(busy_m));

   bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
      .clk(clk), .reset(reset), .din(din_l), .din_valid(dv_l), .din_ready(rdy_l),
      .w(w_l), .w_valid(wv_l), .sof(sof_l), .busy(busy_l));

   int tests = 0;
   int fails = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // exp packs {w, w_valid, sof, busy, din_ready}
   typedef struct {
      logic [W-1:0] din;
      logic         dv;
      logic [4:0]   exp;
   } vec_t;

   vec_t tbl[$];
   localparam logic [4:0] IDLE_OUT = 5'b00001;

   function automatic void add(input logic [W-1:0] d, input logic v, input logic [4:0] e);
      vec_t r;
      r.din = d; r.dv = v; r.exp = e;
      tbl.push_back(r);
   endfunction

   logic [1:0] qm[$];
   logic [1:0] ql[$];
   logic [1:0] junk;
   logic [4:0] em, el;
   logic       xm, xl;
   logic [7:0] wd, wa, wb, wl;

   initial begin
      wd = 8'hD6; wa = 8'hA5; wb = 8'h3C; wl = 8'h01;

      // Single word D6, then idle.
      add(wd, 1'b1, IDLE_OUT);
      for (int i = 1; i <= 8; i++) add('0, 1'b0, {wd[8-i], 1'b1, i == 1, 1'b1, i == 8});
      add('0, 1'b0, IDLE_OUT);
      // A5 then 3C held valid the whole time; 3C only lands on A5's last bit.
      add(wa, 1'b1, IDLE_OUT);
      for (int i = 1; i <= 8; i++) add(wb, 1'b1, {wa[8-i], 1'b1, i == 1, 1'b1, i == 8});
      for (int i = 1; i <= 8; i++) add('0, 1'b0, {wb[8-i], 1'b1, i == 1, 1'b1, i == 8});
      add('0, 1'b0, IDLE_OUT);

      // Reset held with valid asserted: nothing captured.
      reset = 1'b0;
      din_m = 8'hFF; dv_m = 1'b1;
      din_l = 8'hFF; dv_l = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("rst_outs", {w_m, wv_m, sof_m, busy_m, rdy_m}, IDLE_OUT);
         chk("rst_outs_lsb", {w_l, wv_l, sof_l, busy_l, rdy_l}, IDLE_OUT);
      end

      // Release with an LSB-first word already offered: first edge captures it.
      reset = 1'b1;
      dv_m = 1'b0;
      din_l = wl; dv_l = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         dv_l = 1'b0;
         chk("lsb_bit", {w_l, wv_l, sof_l, busy_l, rdy_l},
             {wl[i], 1'b1, i == 0, 1'b1, i == 7});
      end
      @(negedge clk);
      chk("lsb_idle", {w_l, wv_l, sof_l, busy_l, rdy_l}, IDLE_OUT);

      foreach (tbl[k]) begin
         @(negedge clk);
         chk($sformatf("vec%0d", k), {w_m, wv_m, sof_m, busy_m, rdy_m}, tbl[k].exp);
         din_m = tbl[k].din;
         dv_m  = tbl[k].dv;
      end

      // Reset in the middle of an all-ones word.
      @(negedge clk);
      din_m = 8'hFF; dv_m = 1'b1;
      @(negedge clk);
      dv_m = 1'b0;
      repeat (3) @(negedge clk);
      chk("mid_bit4", {w_m, wv_m, busy_m}, 3'b111);
      #2 reset = 1'b0;
      #1 chk("mid_async", {w_m, wv_m, sof_m, busy_m, rdy_m}, IDLE_OUT);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("mid_noresume", {w_m, wv_m, sof_m, busy_m, rdy_m}, IDLE_OUT);
      @(negedge clk);
      chk("mid_noresume2", {w_m, wv_m, sof_m, busy_m, rdy_m}, IDLE_OUT);

      // Random traffic against a queue of pending {bit, first} pairs per instance.
      for (int c = 0; c < 1500; c++) begin
         @(negedge clk);
         em = (qm.size() == 0) ? IDLE_OUT : {qm[0][1], 1'b1, qm[0][0], 1'b1, qm.size() == 1};
         el = (ql.size() == 0) ? IDLE_OUT : {ql[0][1], 1'b1, ql[0][0], 1'b1, ql.size() == 1};
         chk("rand_msb", {w_m, wv_m, sof_m, busy_m, rdy_m}, em);
         chk("rand_lsb", {w_l, wv_l, sof_l, busy_l, rdy_l}, el);
         din_m = W'($urandom);
         din_l = W'($urandom);
         dv_m  = ($urandom_range(0, 3) != 0);
         dv_l  = ($urandom_range(0, 2) != 0);
         xm = dv_m && (qm.size() <= 1);
         xl = dv_l && (ql.size() <= 1);
         @(posedge clk);
         if (qm.size() > 0) junk = qm.pop_front();
         if (ql.size() > 0) junk = ql.pop_front();
         if (xm) for (int i = 0; i < W; i++) qm.push_back({din_m[W-1-i], i == 0});
         if (xl) for (int i = 0; i < W; i++) ql.push_back({din_l[i], i == 0});
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
